hex_word_parser: RTL and testbench

Converts a stream of ASCII bytes from the serial receiver into 16-bit TOY words and presents them on a `stdio` output port. It sits directly upstream of the stdin FIFO, which buffers words for the TOY core. Up to four hexadecimal digits form one word. Whitespace separates words, and invalid characters flag an error and discard the partial word.

---
 rtl/hex_word_parser_pkg.sv | 23 ++
 rtl/stdio.sv | 11 +
 rtl/hex_word_parser_hex_char_decode.sv | 31 +++
 rtl/hex_word_parser.sv | 95 +++++++++
 tb/tb_hex_word_parser.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_word_parser_pkg.sv
// Shared types and character constants for the ASCII-to-word parser.
package hex_word_parser_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        CH_HEX,
        CH_SEP,
        CH_ILL
    } chclass_e;

    typedef enum logic [1:0] {
        HEXP_IDLE,
        HEXP_ACCUM,
        HEXP_HOLD
    } hexp_state_e;

endpackage

// File: rtl/stdio.sv
// Valid/ready word channel between the parser and the stdin FIFO.
interface stdio #(
    parameter int DATA_W = 16
);
    logic              val;
    logic              rdy;
    logic [DATA_W-1:0] data;

    modport out (output val, output data, input rdy);
    modport in  (input val, input data, output rdy);
endinterface

// File: rtl/hex_word_parser_hex_char_decode.sv
// Classifies one ASCII byte as hex digit, separator or illegal.
// Lower-case a-f decode as digits only when HEX_PARSER_LOWERCASE_EN is defined.
module hex_char_decode
    import hex_word_parser_pkg::*;
(
    input  logic [7:0] ch,
    output chclass_e   cls,
    output logic [3:0] nibble
);

    always_comb begin
        cls    = CH_ILL;
        nibble = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            cls    = CH_HEX;
            nibble = ch[3:0];
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            // 'A' is 0x41, so the low nibble plus 9 gives 10..15
            cls    = CH_HEX;
            nibble = ch[3:0] + 4'd9;
`ifdef HEX_PARSER_LOWERCASE_EN
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            cls    = CH_HEX;
            nibble = ch[3:0] + 4'd9;
`endif
        end else if (ch == CH_SPACE || ch == CH_TAB || ch == CH_LF || ch == CH_CR) begin
            cls = CH_SEP;
        end
    end

endmodule

// File: rtl/hex_word_parser.sv
// Assembles up to four ASCII hex digits into a 16-bit word on a stdio port.
// Build option HEX_PARSER_LOWERCASE_EN enables lower-case hex digits.
module hex_word_parser
    import hex_word_parser_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_val_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_rdy_o,
    stdio.out          stdout,
    output logic       err_o
);

    hexp_state_e        state_q;
    logic [DATA_W-1:0]  acc_q;
    logic [1:0]         cnt_q;
    logic               val_q;
    logic               err_q;
    chclass_e           cls;
    logic [3:0]         nibble;
    logic               accept;

    hex_char_decode u_decode (
        .ch     (rx_data_i),
        .cls    (cls),
        .nibble (nibble)
    );

    assign rx_rdy_o    = (state_q != HEXP_HOLD);
    assign accept      = rx_val_i && rx_rdy_o;
    assign stdout.val  = val_q;
    assign stdout.data = acc_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HEXP_IDLE;
            acc_q   <= '0;
            cnt_q   <= 2'd0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                HEXP_IDLE: begin
                    if (accept) begin
                        if (cls == CH_HEX) begin
                            acc_q   <= {12'h000, nibble};
                            cnt_q   <= 2'd1;
                            state_q <= HEXP_ACCUM;
                        end else if (cls == CH_ILL) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HEXP_ACCUM: begin
                    if (accept) begin
                        unique case (cls)
                            CH_HEX: begin
                                acc_q <= {acc_q[11:0], nibble};
                                if (cnt_q == 2'd3) begin
                                    cnt_q   <= 2'd0;
                                    val_q   <= 1'b1;
                                    state_q <= HEXP_HOLD;
                                end else begin
                                    cnt_q <= cnt_q + 2'd1;
                                end
                            end
                            CH_SEP: begin
                                cnt_q   <= 2'd0;
                                val_q   <= 1'b1;
                                state_q <= HEXP_HOLD;
                            end
                            default: begin
                                err_q   <= 1'b1;
                                acc_q   <= '0;
                                cnt_q   <= 2'd0;
                                state_q <= HEXP_IDLE;
                            end
                        endcase
                    end
                end
                HEXP_HOLD: begin
                    if (stdout.rdy) begin
                        val_q   <= 1'b0;
                        state_q <= HEXP_IDLE;
                    end
                end
                default: state_q <= HEXP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_parser.sv
// Scoreboard bench for hex_word_parser: expected words queued at stimulus time.
module tb_hex_word_parser;

    logic        clk_i     = 1'b0;
    logic        rst_ni    = 1'b0;
    logic        rx_val_i  = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_rdy_o;
    logic        err_o;

    stdio #(.DATA_W(16)) stdout_if ();

    hex_word_parser dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rx_val_i  (rx_val_i),
        .rx_data_i (rx_data_i),
        .rx_rdy_o  (rx_rdy_o),
        .stdout    (stdout_if),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          err_cnt = 0;
    int          word_cnt = 0;
    logic [15:0] exp_q[$];

`ifdef HEX_PARSER_LOWERCASE_EN
    localparam bit LOWER_EN = 1'b1;
`else
    localparam bit LOWER_EN = 1'b0;
`endif

    // Output monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (err_o === 1'b1) err_cnt++;
            if (stdout_if.val === 1'b1 && stdout_if.rdy === 1'b1) begin
                logic [15:0] e;
                word_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL word_unexpected: got %h, expected no word", stdout_if.data);
                end else begin
                    e = exp_q.pop_front();
                    if (stdout_if.data !== e) begin
                        n_fail++;
                        $display("FAIL word_data: got %h, expected %h", stdout_if.data, e);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        rx_val_i  = 1'b1;
        rx_data_i = b;
        for (int t = 0; t < 60 && !done; t++) begin
            done = (rx_rdy_o === 1'b1);
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted, rx_rdy_o %b", b, rx_rdy_o);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        rx_val_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        stdout_if.rdy = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++;
        if (rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rx_rdy: got %b, expected 1", rx_rdy_o); end
        n_tests++;
        if (stdout_if.val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b, expected 0", stdout_if.val); end
        n_tests++;
        if (stdout_if.data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h, expected 0000", stdout_if.data); end
        n_tests++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err_o); end
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic();
        int e0 = err_cnt;
        int w0 = word_cnt;
        stdout_if.rdy = 1'b1;
        exp_q.push_back(16'h1A2B);
        send_str("1A2");
        send_byte("B");
        n_tests++;
        if (stdout_if.val !== 1'b1 || stdout_if.data !== 16'h1A2B) begin
            n_fail++;
            $display("FAIL basic_latency: val %b data %h, expected val 1 data 1a2b", stdout_if.val, stdout_if.data);
        end
        send_str("\n");
        drain("basic");
        n_tests++;
        if (word_cnt - w0 != 1) begin n_fail++; $display("FAIL basic_words: got %0d, expected 1", word_cnt - w0); end
        n_tests++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL basic_err: got %0d pulses, expected 0", err_cnt - e0); end
    endtask

    task automatic test_short_and_sep();
        int e0 = err_cnt;
        int w0;
        exp_q.push_back(16'h007F);
        send_str("7F ");
        drain("short");
        w0 = word_cnt;
        send_str("  \r\n\t");
        drain("seps");
        n_tests++;
        if (word_cnt != w0) begin n_fail++; $display("FAIL seps_words: got %0d, expected 0", word_cnt - w0); end
        n_tests++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL seps_err: got %0d pulses, expected 0", err_cnt - e0); end
    endtask

    task automatic test_illegal();
        int e0 = err_cnt;
        exp_q.push_back(16'h0004);
        send_str("12G4 ");
        drain("illegal");
        n_tests++;
        if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL illegal_err: got %0d pulses, expected 1", err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b1;
        stdout_if.rdy = 1'b0;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        send_str("1234");
        rx_val_i  = 1'b1;
        rx_data_i = "5";
        for (int c = 0; c < 10; c++) begin
            if (rx_rdy_o !== 1'b0 || stdout_if.val !== 1'b1 || stdout_if.data !== 16'h1234) begin
                if (ok) $display("FAIL hold_stable: rdy %b val %b data %h, expected 0 1 1234",
                                 rx_rdy_o, stdout_if.val, stdout_if.data);
                ok = 1'b0;
            end
            @(posedge clk_i);
            #1;
        end
        n_tests++;
        if (!ok) n_fail++;
        stdout_if.rdy = 1'b1;
        send_str("5678");
        drain("b2b");
    endtask

    task automatic test_lowercase();
        int e0 = err_cnt;
        exp_q.push_back(LOWER_EN ? 16'hAB12 : 16'h0012);
        send_str("ab12 ");
        drain("lower");
        n_tests++;
        if (err_cnt - e0 != (LOWER_EN ? 0 : 2)) begin
            n_fail++;
            $display("FAIL lower_err: got %0d pulses, expected %0d", err_cnt - e0, LOWER_EN ? 0 : 2);
        end
    endtask

    task automatic test_async_reset();
        int e0 = err_cnt;
        stdout_if.rdy = 1'b1;
        send_str("9F");
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if (rx_rdy_o !== 1'b1 || stdout_if.val !== 1'b0 || stdout_if.data !== 16'h0000 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_accum: rdy %b val %b data %h err %b, expected 1 0 0000 0",
                     rx_rdy_o, stdout_if.val, stdout_if.data, err_o);
        end
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        stdout_if.rdy = 1'b0;
        send_str("0001");
        n_tests++;
        if (stdout_if.val !== 1'b1) begin n_fail++; $display("FAIL rst_pre_hold: val %b, expected 1", stdout_if.val); end
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if (rx_rdy_o !== 1'b1 || stdout_if.val !== 1'b0 || stdout_if.data !== 16'h0000 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold: rdy %b val %b data %h err %b, expected 1 0 0000 0",
                     rx_rdy_o, stdout_if.val, stdout_if.data, err_o);
        end
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        stdout_if.rdy = 1'b1;
        exp_q.push_back(16'h0001);
        send_str("0001 ");
        drain("post_rst");
        n_tests++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL rst_err: got %0d pulses, expected 0", err_cnt - e0); end
    endtask

    initial begin
        stdout_if.rdy = 1'b0;
        test_reset();
        test_basic();
        test_short_and_sep();
        test_illegal();
        test_back_to_back();
        test_lowercase();
        test_async_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d words outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
